tetris_game_sequencer: RTL

//  Top-level game-flow controller for the falling-piece engine (CurrBlock).

---
 rtl/tetris_game_sequencer_if.sv | 49 ++++
 rtl/tetris_game_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tetris_game_sequencer_if.sv
// -----------------------------------------------------------------------------
// tetris_game_sequencer_if
// Purpose : Bundles the game-flow controller's playfield-side signals so the
//           sequencer and its environment (timing/keyboard front end and the
//           CurrBlock engine) connect through a single port.
// Signals :
//   frame_tick    - 1-cycle pulse per video frame
//   startGame     - level-sensitive start/restart request
//   fell          - CurrBlock: piece landed, must lock
//   currBlocks    - CurrBlock: active-piece bitmap, [row][col]
//   Spawn         - 1-cycle pulse: load a new piece
//   drop_tick     - 1-cycle pulse: gravity step
//   fallenBlocks  - settled playfield, [row][col]
//   difficulty    - gravity period in frames
//   level         - current level (saturates at 15)
//   lines_cleared - total cleared lines (saturates at 16'hFFFF)
//   lineBreak     - 1-cycle pulse per removed row
//   gameOver      - high while the game is over
// Modports: master = sequencer side, slave = environment side.
// -----------------------------------------------------------------------------
interface tetris_game_sequencer_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  logic                       frame_tick;
  logic                       startGame;
  logic                       fell;
  logic [ROWS-1:0][COLS-1:0]  currBlocks;
  logic                       Spawn;
  logic                       drop_tick;
  logic [ROWS-1:0][COLS-1:0]  fallenBlocks;
  logic [9:0]                 difficulty;
  logic [3:0]                 level;
  logic [15:0]                lines_cleared;
  logic                       lineBreak;
  logic                       gameOver;

  modport master (
    input  frame_tick, startGame, fell, currBlocks,
    output Spawn, drop_tick, fallenBlocks, difficulty, level,
           lines_cleared, lineBreak, gameOver
  );

  modport slave (
    output frame_tick, startGame, fell, currBlocks,
    input  Spawn, drop_tick, fallenBlocks, difficulty, level,
           lines_cleared, lineBreak, gameOver
  );
endinterface

// File: rtl/tetris_game_sequencer.sv
// -----------------------------------------------------------------------------
// tetris_game_sequencer
// Purpose : Game-flow controller for the falling-piece engine. Sequences
//           spawn -> gravity fall -> lock -> line clear -> respawn, owns the
//           settled playfield and the gravity timer, and detects game over.
// Ports   :
//   i_clk   - system clock
//   i_reset - asynchronous reset, active-high
//   io_bus  - tetris_game_sequencer_if.master (see interface for signals)
// -----------------------------------------------------------------------------
module tetris_game_sequencer #(
  parameter int ROWS            = 20,
  parameter int COLS            = 10,
  parameter int BASE_PERIOD     = 48,
  parameter int PERIOD_STEP     = 4,
  parameter int MIN_PERIOD      = 4,
  parameter int LINES_PER_LEVEL = 10,
  parameter int SPAWN_WAIT      = 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  tetris_game_sequencer_if.master         io_bus
);
  localparam int IDX_W = $clog2(ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_WAIT, S_FALL, S_LOCK, S_SCAN, S_OVER
  } state_t;

  state_t                     r_state, w_state_next;
  logic [ROWS-1:0][COLS-1:0]  r_board;
  logic [IDX_W-1:0]           r_idx;
  logic [9:0]                 r_frame_cnt;
  logic [7:0]                 r_wait_cnt;
  logic [3:0]                 r_level;
  logic [15:0]                r_lines;
  logic [15:0]                r_lvl_lines;   // clears since the last level-up
  logic [9:0]                 r_difficulty;
  logic                       r_start_prev;

  logic [ROWS-1:0]            w_row_hit;
  logic                       w_overlap;
  logic                       w_row_full;
  logic                       w_tick_hit;
  logic signed [10:0]         w_period;
  logic [9:0]                 w_diff_next;
  logic                       w_spawn, w_drop, w_line_break, w_game_over;

  // Spawn collision: any settled cell covered by the freshly loaded piece.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_overlap
    assign w_row_hit[gi] = |(io_bus.currBlocks[gi] & r_board[gi]);
  end
  assign w_overlap  = |w_row_hit;
  assign w_row_full = &r_board[r_idx];
  assign w_tick_hit = io_bus.frame_tick && (r_frame_cnt == r_difficulty - 10'd1);

  // Signed so that high levels go negative instead of wrapping before the floor.
  assign w_period    = $signed(11'(BASE_PERIOD)) - $signed({7'd0, r_level} * 11'(PERIOD_STEP));
  assign w_diff_next = (w_period < $signed(11'(MIN_PERIOD))) ? 10'(MIN_PERIOD) : w_period[9:0];

  always_comb begin
    w_state_next = r_state;
    w_spawn      = 1'b0;
    w_drop       = 1'b0;
    w_line_break = 1'b0;
    w_game_over  = 1'b0;
    case (r_state)
      S_IDLE:  if (io_bus.startGame) w_state_next = S_SPAWN;
      S_SPAWN: begin
        w_spawn      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT:  if (r_wait_cnt == 8'd0) w_state_next = w_overlap ? S_OVER : S_FALL;
      S_FALL: begin
        // Locking wins over a gravity step landing in the same cycle.
        if (io_bus.fell)     w_state_next = S_LOCK;
        else if (w_tick_hit) w_drop = 1'b1;
      end
      S_LOCK:  w_state_next = S_SCAN;
      S_SCAN: begin
        if (w_row_full)               w_line_break = 1'b1;
        else if (r_idx == '0)         w_state_next = S_SPAWN;
      end
      S_OVER: begin
        w_game_over = 1'b1;
        if (io_bus.startGame && !r_start_prev) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_board      <= '0;
      r_idx        <= '0;
      r_frame_cnt  <= '0;
      r_wait_cnt   <= '0;
      r_level      <= '0;
      r_lines      <= '0;
      r_lvl_lines  <= '0;
      r_difficulty <= 10'(BASE_PERIOD);
      r_start_prev <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_start_prev <= io_bus.startGame;
      r_difficulty <= w_diff_next;
      case (r_state)
        S_IDLE: if (io_bus.startGame) begin
          r_board     <= '0;
          r_level     <= '0;
          r_lines     <= '0;
          r_lvl_lines <= '0;
          r_frame_cnt <= '0;
        end
        S_SPAWN: r_wait_cnt <= 8'(SPAWN_WAIT);
        S_WAIT: begin
          if (r_wait_cnt != 8'd0) r_wait_cnt  <= r_wait_cnt - 8'd1;
          else                    r_frame_cnt <= '0;
        end
        S_FALL: if (!io_bus.fell && io_bus.frame_tick)
          r_frame_cnt <= w_tick_hit ? 10'd0 : r_frame_cnt + 10'd1;
        S_LOCK: begin
          for (int r = 0; r < ROWS; r++) r_board[r] <= r_board[r] | io_bus.currBlocks[r];
          r_idx <= IDX_W'(ROWS - 1);
        end
        S_SCAN: begin
          if (w_row_full) begin
            // Collapse everything above the full row by one; idx stays put
            // so the row that slid in is examined next cycle.
            for (int r = 1; r < ROWS; r++)
              if (IDX_W'(r) <= r_idx) r_board[r] <= r_board[r-1];
            r_board[0] <= '0;
            if (r_lines != 16'hFFFF) begin
              r_lines <= r_lines + 16'd1;
              if (r_lvl_lines == 16'(LINES_PER_LEVEL - 1)) begin
                r_lvl_lines <= '0;
                if (r_level != 4'd15) r_level <= r_level + 4'd1;
              end else begin
                r_lvl_lines <= r_lvl_lines + 16'd1;
              end
            end
          end else if (r_idx != '0) begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.Spawn         = w_spawn;
  assign io_bus.drop_tick     = w_drop;
  assign io_bus.lineBreak     = w_line_break;
  assign io_bus.gameOver      = w_game_over;
  assign io_bus.fallenBlocks  = r_board;
  assign io_bus.difficulty    = r_difficulty;
  assign io_bus.level         = r_level;
  assign io_bus.lines_cleared = r_lines;
endmodule
